// File: rtl/store_merge_unit.sv
// Store path of the MEM stage: commits sw/sh/sb to a word-wide synchronous-read memory,
// using read-modify-write for sub-word stores and rejecting misaligned accesses.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for StoreReq; latches the request when it arrives
// S_READ  | MemRead strobe for the word holding the sub-word target
// S_MERGE | memory word is valid; merge new lanes into MemWriteData
// S_WRITE | MemWrite strobe with the final word, Done pulse
// S_ERR   | misaligned store rejected, Misaligned + Done pulse
module store_merge_unit #(
    parameter int ADDR_W = 10
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              StoreReq,
    input  logic [1:0]        sel,
    input  logic [31:0]       Address,
    input  logic [31:0]       WriteData,
    input  logic [31:0]       MemReadData,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [31:0]       MemWriteData,
    output logic              Stall,
    output logic              Done,
    output logic              Misaligned
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_MERGE = 3'd2,
        S_WRITE = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_sel;
    logic [1:0]        r_byte_off;
    logic [15:0]       r_wdata;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;

    logic              w_is_sw;
    logic              w_misaligned;
    logic              w_accept;
    logic [31:0]       w_merged;

    // Upper byte-address bits lie outside the memory and are intentionally dropped.
    logic              w_unused_addr;
    assign w_unused_addr = ^Address[31:ADDR_W+2];

    // sel = 11 behaves exactly like sw.
    assign w_is_sw      = (sel == 2'b00) || (sel == 2'b11);
    assign w_misaligned = w_is_sw ? (Address[1:0] != 2'b00)
                                  : ((sel == 2'b01) && Address[0]);
    assign w_accept     = (r_state == S_IDLE) && StoreReq;

    always_comb begin
        w_merged = MemReadData;
        if (r_sel == 2'b10) begin
            case (r_byte_off)
                2'b00:   w_merged[7:0]   = r_wdata[7:0];
                2'b01:   w_merged[15:8]  = r_wdata[7:0];
                2'b10:   w_merged[23:16] = r_wdata[7:0];
                default: w_merged[31:24] = r_wdata[7:0];
            endcase
        end else if (r_byte_off[1]) begin
            w_merged[31:16] = r_wdata;
        end else begin
            w_merged[15:0] = r_wdata;
        end
    end

    always_comb begin
        w_next     = r_state;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        Done       = 1'b0;
        Misaligned = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (StoreReq) begin
                    if (w_misaligned)  w_next = S_ERR;
                    else if (w_is_sw)  w_next = S_WRITE;
                    else               w_next = S_READ;
                end
            end
            S_READ: begin
                MemRead = 1'b1;
                w_next  = S_MERGE;
            end
            S_MERGE: w_next = S_WRITE;
            S_WRITE: begin
                MemWrite = 1'b1;
                Done     = 1'b1;
                w_next   = S_IDLE;
            end
            S_ERR: begin
                Misaligned = 1'b1;
                Done       = 1'b1;
                w_next     = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign Stall = w_accept || (r_state == S_READ) || (r_state == S_MERGE);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_sel       <= 2'b00;
            r_byte_off  <= 2'b00;
            r_wdata     <= 16'h0000;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'h0000_0000;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_sel      <= sel;
                r_byte_off <= Address[1:0];
                r_wdata    <= WriteData[15:0];
                r_mem_addr <= Address[ADDR_W+1:2];
                if (w_is_sw && !w_misaligned) r_mem_wdata <= WriteData;
            end
            if (r_state == S_MERGE) r_mem_wdata <= w_merged;
        end
    end

    assign MemAddr      = r_mem_addr;
    assign MemWriteData = r_mem_wdata;

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit with a behavioural synchronous-read word memory.
module tb_store_merge_unit;

    logic        Clk;
    logic        Reset;
    logic        StoreReq;
    logic [1:0]  sel;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] MemReadData;
    logic [9:0]  MemAddr;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] MemWriteData;
    logic        Stall;
    logic        Done;
    logic        Misaligned;

    int checks = 0;
    int errors = 0;
    int wr_total = 0;

    logic [31:0] mem [0:1023];
    logic        pre_we = 1'b0;
    logic [9:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    store_merge_unit #(.ADDR_W(10)) dut (
        .Clk(Clk), .Reset(Reset), .StoreReq(StoreReq), .sel(sel),
        .Address(Address), .WriteData(WriteData), .MemReadData(MemReadData),
        .MemAddr(MemAddr), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemWriteData(MemWriteData), .Stall(Stall), .Done(Done),
        .Misaligned(Misaligned)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) begin
        if (MemRead) MemReadData <= mem[MemAddr];
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (MemWrite) mem[MemAddr] <= MemWriteData;
        if (MemWrite) wr_total <= wr_total + 1;
    end

    always @(negedge Clk) begin
        if (!Reset) begin
            checks++;
            if (MemRead && MemWrite) begin
                errors++;
                $display("FAIL strobe_exclusive: MemRead=%0b MemWrite=%0b required not both", MemRead, MemWrite);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        @(negedge Clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge Clk);
        pre_we = 1'b0;
    endtask

    task automatic check_idle(input string name);
        check({name, "_idle_strobes"}, {28'd0, MemRead, MemWrite, Done, Misaligned}, 32'd0);
        check({name, "_idle_stall"}, {31'd0, Stall}, 32'd0);
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] init_word;
        logic [31:0] exp_word;
        logic        exp_mis;
    } vec_t;

    vec_t vecs [13];

    initial begin
        vecs[0]  = '{2'b10, 32'h0000_0011, 32'h0000_0077, 32'hAABB_CCDD, 32'hAABB_77DD, 1'b0};
        vecs[1]  = '{2'b01, 32'h0000_0012, 32'hFFFF_1234, 32'hAABB_CCDD, 32'h1234_CCDD, 1'b0};
        vecs[2]  = '{2'b01, 32'h0000_0010, 32'hFFFF_1234, 32'hAABB_CCDD, 32'hAABB_1234, 1'b0};
        vecs[3]  = '{2'b00, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        vecs[4]  = '{2'b01, 32'h0000_0013, 32'h0000_5555, 32'hAABB_CCDD, 32'hAABB_CCDD, 1'b1};
        vecs[5]  = '{2'b00, 32'h0000_0022, 32'h1111_2222, 32'h5555_5555, 32'h5555_5555, 1'b1};
        vecs[6]  = '{2'b10, 32'h0000_0013, 32'h1234_5699, 32'h0102_0304, 32'h9902_0304, 1'b0};
        vecs[7]  = '{2'b10, 32'h0000_0010, 32'h0000_00AB, 32'h1122_3344, 32'h1122_33AB, 1'b0};
        vecs[8]  = '{2'b10, 32'h0000_0012, 32'h0000_005A, 32'hFFFF_FFFF, 32'hFF5A_FFFF, 1'b0};
        vecs[9]  = '{2'b11, 32'h0000_0040, 32'hCAFE_F00D, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
        vecs[10] = '{2'b11, 32'h0000_0041, 32'hCAFE_F00D, 32'h7777_7777, 32'h7777_7777, 1'b1};
        vecs[11] = '{2'b01, 32'h0000_000E, 32'h0000_BEEF, 32'h1234_5678, 32'hBEEF_5678, 1'b0};
        vecs[12] = '{2'b10, 32'h0000_1007, 32'h0000_0042, 32'h0000_0000, 32'h4200_0000, 1'b0};

        Reset = 1'b1; StoreReq = 1'b0; sel = 2'b00; Address = '0; WriteData = '0;
        repeat (3) @(negedge Clk);
        check("reset_memaddr", {22'd0, MemAddr}, 32'd0);
        check("reset_wdata", MemWriteData, 32'd0);
        check("reset_strobes", {28'd0, MemRead, MemWrite, Done, Misaligned}, 32'd0);
        check("reset_stall", {31'd0, Stall}, 32'd0);
        Reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            vec_t        v;
            logic [9:0]  waddr;
            logic        is_sw;
            int rd_cyc, wr_cyc, mis_cyc, done_cyc, rd_cnt, wr_cnt, stall_cnt;
            int exp_wr_cyc;
            logic [31:0] rd_addr, wr_addr, wr_data;
            string tag;
            v = vecs[i];
            waddr = v.addr[11:2];
            is_sw = (v.sel == 2'b00) || (v.sel == 2'b11);
            exp_wr_cyc = v.exp_mis ? 0 : (is_sw ? 1 : 3);
            tag = $sformatf("vec%0d", i);
            rd_cyc = 0; wr_cyc = 0; mis_cyc = 0; done_cyc = 0;
            rd_cnt = 0; wr_cnt = 0; stall_cnt = 0;
            rd_addr = '0; wr_addr = '0; wr_data = '0;
            preload(waddr, v.init_word);

            @(negedge Clk);
            sel = v.sel; Address = v.addr; WriteData = v.wdata; StoreReq = 1'b1;
            #1;
            if (Stall) stall_cnt++;
            for (int k = 1; k <= 6; k++) begin
                @(negedge Clk);
                if (k == 1) begin
                    sel = ~v.sel; Address = v.addr ^ 32'h0000_0A5F; WriteData = ~v.wdata;
                end
                if (MemRead)  begin rd_cyc = k; rd_cnt++; rd_addr = {22'd0, MemAddr}; end
                if (MemWrite) begin wr_cyc = k; wr_cnt++; wr_addr = {22'd0, MemAddr}; wr_data = MemWriteData; end
                if (Misaligned) mis_cyc = k;
                if (Stall) stall_cnt++;
                if (Done) begin
                    done_cyc = k;
                    break;
                end
            end
            StoreReq = 1'b0;
            @(negedge Clk);
            check({tag, "_done_cycle"}, done_cyc, v.exp_mis || is_sw ? 1 : 3);
            check({tag, "_mis_cycle"}, mis_cyc, v.exp_mis ? 1 : 0);
            check({tag, "_read_count"}, rd_cnt, (v.exp_mis || is_sw) ? 0 : 1);
            check({tag, "_write_count"}, wr_cnt, v.exp_mis ? 0 : 1);
            check({tag, "_write_cycle"}, wr_cyc, exp_wr_cyc);
            check({tag, "_stall_cycles"}, stall_cnt, (v.exp_mis || is_sw) ? 1 : 3);
            if (!v.exp_mis && !is_sw) begin
                check({tag, "_read_cycle"}, rd_cyc, 1);
                check({tag, "_read_addr"}, rd_addr, {22'd0, waddr});
            end
            if (!v.exp_mis) begin
                check({tag, "_write_addr"}, wr_addr, {22'd0, waddr});
                check({tag, "_write_data"}, wr_data, v.exp_word);
            end
            check({tag, "_mem_word"}, mem[waddr], v.exp_word);
            check_idle(tag);
        end

        // Reset asserted during MERGE must abort the store without a write.
        begin
            int wr0;
            preload(10'd4, 32'hAABB_CCDD);
            wr0 = wr_total;
            @(negedge Clk);
            sel = 2'b10; Address = 32'h11; WriteData = 32'h77; StoreReq = 1'b1;
            @(negedge Clk);
            check("rst_read_strobe", {31'd0, MemRead}, 32'd1);
            @(negedge Clk);
            check("rst_merge_stall", {31'd0, Stall}, 32'd1);
            Reset = 1'b1; StoreReq = 1'b0;
            @(negedge Clk);
            check("rst_after_wdata", MemWriteData, 32'd0);
            check("rst_after_memaddr", {22'd0, MemAddr}, 32'd0);
            check("rst_after_strobes", {30'd0, MemRead, MemWrite}, 32'd0);
            Reset = 1'b0;
            repeat (3) @(negedge Clk);
            check_idle("rst");
            check("rst_write_pulses", wr_total - wr0, 0);
            check("rst_mem_word", mem[4], 32'hAABB_CCDD);
        end

        // Two sb stores with StoreReq held continuously.
        begin
            int wr0;
            preload(10'd4, 32'hAABB_CCDD);
            wr0 = wr_total;
            @(negedge Clk);
            sel = 2'b10; Address = 32'h11; WriteData = 32'h77; StoreReq = 1'b1;
            @(negedge Clk);
            check("b2b_read1", {31'd0, MemRead}, 32'd1);
            @(negedge Clk);
            @(negedge Clk);
            check("b2b_write1", {31'd0, MemWrite}, 32'd1);
            check("b2b_data1", MemWriteData, 32'hAABB_77DD);
            check("b2b_write1_stall", {31'd0, Stall}, 32'd0);
            Address = 32'h13; WriteData = 32'h99;
            @(negedge Clk);
            check("b2b_accept2_stall", {31'd0, Stall}, 32'd1);
            check("b2b_accept2_strobes", {30'd0, MemRead, MemWrite}, 32'd0);
            @(negedge Clk);
            check("b2b_read2", {31'd0, MemRead}, 32'd1);
            check("b2b_read2_addr", {22'd0, MemAddr}, 32'd4);
            @(negedge Clk);
            @(negedge Clk);
            check("b2b_write2", {31'd0, MemWrite}, 32'd1);
            check("b2b_data2", MemWriteData, 32'h99BB_77DD);
            StoreReq = 1'b0;
            @(negedge Clk);
            check_idle("b2b");
            check("b2b_write_pulses", wr_total - wr0, 2);
            check("b2b_mem_word", mem[4], 32'h99BB_77DD);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
